serv_rf_ram_bridge: RTL
=======================

# serv_rf_ram_bridge

Responder side of the bit-serial register-file interface. Accepts the serial read/write requests the core's RF interface issues (6-bit register addresses, two read bit-streams, two write bit-streams) and services them against a simple dual-port synchronous RAM of configurable word width. It holds the serial↔parallel buffering, the bit counters and the RAM address generation, and sits between the core and the RF RAM macro.

## Interface
- WIDTH, 2, RAM data width in bits; legal 2, 4, 8, 16, 32.
- WITH_CSR, 1, 1: 6-bit register address (32 GPRs + CSRs at 32–35); 0: 5-bit.
- Derived: RW = 5+WITH_CSR; AW = RW + 5 − log2(WIDTH).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_rreq  in  1  one-cycle pulse: start read transaction.
- i_wreq  in  1  one-cycle pulse: start write transaction.
- o_ready  out  1  one-cycle pulse: transaction ready/done.
- i_rreg0, i_rreg1  in  RW  read register addresses, sampled with i_rreq.
- o_rdata0, o_rdata1  out  1  serial read data, LSB first.
- i_wreg0, i_wreg1  in  RW  write register addresses, sampled with i_wreq.
- i_wen0, i_wen1  in  1  per-port write enables, sampled with i_wreq.
- i_wdata0, i_wdata1  in  1  serial write data, LSB first.
- o_waddr  out  AW  RAM write address {reg, word}.
- o_wdata  out  WIDTH  RAM write data.
- o_wen  out  1  RAM write strobe.
- o_raddr  out  AW  RAM read address.
- o_ren  out  1  RAM read strobe.
- i_rdata  in  WIDTH  RAM read data, valid the cycle after o_ren.

## Operation
- FSM: IDLE, READ, WRITE. Requests accepted only in IDLE; i_rreq/i_wreq outside IDLE ignored (protocol error). i_rreq and i_wreq in same IDLE cycle: WRITE taken, read dropped.
- READ: per word j (0..32/WIDTH−1) issue RAM read of {rreg0, j} then {rreg1, j} on consecutive cycles; returned words double-buffered, shifted out one bit per cycle on o_rdata0/o_rdata1. 32 bits streamed, then IDLE.
- WRITE: one shift register per port gathers WIDTH bits; on word complete, port0 word written to {wreg0, j}, next cycle port1 word to {wreg1, j}. Port with wen=0 generates no o_wen. Address 0 written only if the requester enabled it (x0 filtering is the requester's job).
- Word index = bit counter[4:log2(WIDTH)]; 5-bit bit counter wraps 31→0 at transaction end.
- o_rdata0/1 = 0 outside the 32 bit-cycles of a READ.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-transaction aborts: no further o_wen/o_ren from the next cycle; partial words discarded.
- Read, i_rreq at cycle T: o_ren at T+1+jW (rreg0) and T+2+jW (rreg1); o_ready at T+3; bit i on o_rdata0/1 at T+4+i, i=0..31; IDLE at T+36.
- Write, i_wreq at cycle W: bit i sampled at W+1+i; word j written at W+(j+1)·WIDTH+1 (port0) and +2 (port1); last writes at W+33/W+34; o_ready at W+35; IDLE at W+36.
- WIDTH ≥ 2 guarantees no RAM read-port or write-port collision.

## Configuration
- RF_RAM_ZERO_X0_EN defined: reads of register 0 issue no o_ren for that slot; o_rdata for that port is forced 0 regardless of RAM contents (uninitialised RAM safe). Undefined: register 0 read from RAM like any other.

## Test plan
- Reset held 3 cycles mid-WRITE → o_wen, o_ren, o_ready, o_rdata0/1 all 0 from the cycle after reset sampled; i_rreq after release reads prior RAM contents.
- WIDTH=4, write reg 5 = 0xDEADBEEF (port0), CSR 34 = 0x12345678 (port1) → 8 word writes each, o_waddr {5,0..7}/{34,0..7}, o_ready at W+35.
- Read reg 5 / reg 34 after above → o_ready at T+3; o_rdata0 serialises 0xDEADBEEF, o_rdata1 0x12345678, bit 0 at T+4.
- i_wen1=0, i_wen0=1 → only port0 o_wen pulses (32/WIDTH total).
- i_rreq and i_wreq same cycle → write performed, no o_ren; i_rreq during WRITE ignored.
- RF_RAM_ZERO_X0_EN with RAM word 0 preloaded 0xFFFFFFFF, read reg 0 → o_rdata0 all zeros; without macro → all ones.

Source files
------------

// File: rtl/serv_rf_ram_bridge.sv
// rtl/serv_rf_ram_bridge.sv - bit-serial RF requests serviced against a dual-port RF RAM
// Optional: RF_RAM_ZERO_X0_EN makes register 0 read as zero without touching the RAM.
module serv_rf_ram_bridge #(
  parameter int WIDTH    = 2,
  parameter int WITH_CSR = 1,
  localparam int RW = 5 + WITH_CSR,
  localparam int LW = $clog2(WIDTH),
  localparam int AW = RW + 5 - LW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  input  logic             i_wreq,
  output logic             o_ready,
  input  logic [RW-1:0]    i_rreg0,
  input  logic [RW-1:0]    i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic [RW-1:0]    i_wreg0,
  input  logic [RW-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t           state, state_nxt;
  logic [5:0]       cnt;
  logic [RW-1:0]    rreg0, rreg1, wreg0, wreg1;
  logic             wen0, wen1;
  logic [WIDTH-1:0] rhold0, rsh0, rsh1;
  logic [WIDTH-1:0] wsh0, wsh1, whold1;
  logic             ph0_q, ph1_q;
  logic             rd_ph0, rd_ph1, wr_ph0, wr_ph1;
  logic             zero0, zero1;
  logic [4:0]       wcnt;
  logic [RW+4:0]    raddr_full, waddr_full;
  logic             unused_bits;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (i_wreq) state_nxt = WRITE;
                   else if (i_rreq) state_nxt = READ;
      READ, WRITE: if (cnt == 6'd34) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // cnt counts cycles since the request; both transactions end at cnt == 34
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      ph0_q  <= 1'b0;
      ph1_q  <= 1'b0;
      rreg0  <= '0;
      rreg1  <= '0;
      wreg0  <= '0;
      wreg1  <= '0;
      wen0   <= 1'b0;
      wen1   <= 1'b0;
      rhold0 <= '0;
      rsh0   <= '0;
      rsh1   <= '0;
      wsh0   <= '0;
      wsh1   <= '0;
      whold1 <= '0;
    end else begin
      cnt   <= (state == IDLE) ? 6'd0 : cnt + 6'd1;
      ph0_q <= rd_ph0;
      ph1_q <= rd_ph1;
      if (state == IDLE && i_wreq) begin
        wreg0 <= i_wreg0;
        wreg1 <= i_wreg1;
        wen0  <= i_wen0;
        wen1  <= i_wen1;
      end
      if (state == IDLE && i_rreq && !i_wreq) begin
        rreg0 <= i_rreg0;
        rreg1 <= i_rreg1;
      end
      // port0 word lands one cycle early and waits in rhold0 while the previous word drains
      if (ph0_q) rhold0 <= i_rdata;
      if (ph1_q) begin
        rsh0 <= rhold0;
        rsh1 <= i_rdata;
      end else begin
        rsh0 <= rsh0 >> 1;
        rsh1 <= rsh1 >> 1;
      end
      if (state == WRITE) begin
        wsh0 <= {i_wdata0, wsh0[WIDTH-1:1]};
        wsh1 <= {i_wdata1, wsh1[WIDTH-1:1]};
      end
      if (wr_ph0) whold1 <= wsh1;
    end
  end

  always_comb begin
    rd_ph0 = (state == READ) && !cnt[5] && (cnt[LW-1:0] == '0);
    rd_ph1 = (state == READ) && !cnt[5] && (cnt[LW-1:0] == LW'(1));
    wr_ph0 = (state == WRITE) && (cnt >= 6'(WIDTH)) && (cnt <= 6'd32) && (cnt[LW-1:0] == '0);
    wr_ph1 = (state == WRITE) && (cnt > 6'(WIDTH)) && (cnt <= 6'd33) && (cnt[LW-1:0] == LW'(1));
`ifdef RF_RAM_ZERO_X0_EN
    zero0 = (rreg0 == '0);
    zero1 = (rreg1 == '0);
`else
    zero0 = 1'b0;
    zero1 = 1'b0;
`endif
    raddr_full = {rd_ph0 ? rreg0 : rreg1, cnt[4:0]};
    // last bit of the just-completed word; 5-bit wrap covers the final words
    wcnt       = cnt[4:0] - (wr_ph1 ? 5'd2 : 5'd1);
    waddr_full = {wr_ph1 ? wreg1 : wreg0, wcnt};
    o_ren      = (rd_ph0 && !zero0) || (rd_ph1 && !zero1);
    o_raddr    = o_ren ? raddr_full[RW+4:LW] : '0;
    o_wen      = (wr_ph0 && wen0) || (wr_ph1 && wen1);
    o_waddr    = o_wen ? waddr_full[RW+4:LW] : '0;
    o_wdata    = o_wen ? (wr_ph0 ? wsh0 : whold1) : '0;
    o_ready    = ((state == READ) && (cnt == 6'd2)) || ((state == WRITE) && (cnt == 6'd34));
    o_rdata0   = (state == READ) && (cnt >= 6'd3) && !zero0 && rsh0[0];
    o_rdata1   = (state == READ) && (cnt >= 6'd3) && !zero1 && rsh1[0];
  end

  assign unused_bits = &{1'b0, raddr_full[LW-1:0], waddr_full[LW-1:0]};

endmodule
